// File: rtl/rc4_xor_stream.sv
// XOR stream cipher stage: requests keystream blocks from the RC4 core and
// encrypts a valid/ready plaintext byte stream through one registered output stage.
module rc4_xor_stream #(
   parameter int NUMS_OF_BYTES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       ks_start,
   input  logic                       ks_done,
   input  logic [NUMS_OF_BYTES*8-1:0] ks_data,
   input  logic                       pt_valid,
   input  logic [7:0]                 pt_data,
   input  logic                       pt_last,
   output logic                       pt_ready,
   output logic                       ct_valid,
   output logic [7:0]                 ct_data,
   output logic                       ct_last,
   input  logic                       ct_ready,
   output logic                       busy,
   output logic [15:0]                blk_cnt
);

   localparam int IDX_W = (NUMS_OF_BYTES > 1) ? $clog2(NUMS_OF_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMS_OF_BYTES - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] REQ     = 3'd1;
   localparam logic [2:0] WAIT_KS = 3'd2;
   localparam logic [2:0] STREAM  = 3'd3;
   localparam logic [2:0] DRAIN   = 3'd4;

   logic [2:0]                 state;
   logic [IDX_W-1:0]           idx;
   logic [NUMS_OF_BYTES*8-1:0] ks_buf;
   logic                       ks_done_q;
   logic [7:0]                 ks_byte;
   logic                       done_edge;
   logic                       pt_fire;
   logic                       ct_fire;

   // The core's done is a level, so only a fresh rising edge marks a new block.
   assign done_edge = ks_done && !ks_done_q;
   assign ks_start  = (state == REQ);
   assign busy      = (state != IDLE);
   assign pt_ready  = (state == STREAM) && (!ct_valid || ct_ready);
   assign pt_fire   = pt_valid && pt_ready;
   assign ct_fire   = ct_valid && ct_ready;

   always_comb begin
      ks_byte = '0;
      for (int k = 0; k < NUMS_OF_BYTES; k++) begin
         if (idx == IDX_W'(k)) begin
            ks_byte = ks_buf[k*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ks_done_q <= 1'b0;
      end else begin
         ks_done_q <= ks_done;
      end
   end

   // Block sequencing; a message always starts on a freshly requested block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         ks_buf  <= '0;
         blk_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pt_valid) begin
                  state   <= REQ;
                  blk_cnt <= '0;
               end
            end
            REQ: begin
               state <= WAIT_KS;
            end
            WAIT_KS: begin
               if (done_edge) begin
                  ks_buf  <= ks_data;
                  idx     <= '0;
                  blk_cnt <= blk_cnt + 16'd1;
                  state   <= STREAM;
               end
            end
            STREAM: begin
               if (pt_fire) begin
                  if (pt_last) begin
                     state <= DRAIN;
                  end else if (idx == LAST_IDX) begin
                     state <= REQ;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (ct_fire) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // A load in the same cycle as a downstream accept keeps the stage full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ct_valid <= 1'b0;
         ct_data  <= '0;
         ct_last  <= 1'b0;
      end else if (pt_fire) begin
         ct_valid <= 1'b1;
         ct_data  <= pt_data ^ ks_byte;
         ct_last  <= pt_last;
      end else if (ct_fire) begin
         ct_valid <= 1'b0;
      end
   end

endmodule

// File: doc/rc4_xor_stream.md
Name: rc4_xor_stream

Overview:
- Downstream consumer of the rc4_new_design keystream generator.
- Requests keystream blocks of NUMS_OF_BYTES bytes from the core and latches each block when the core signals `done`.
- XORs a byte-wide plaintext stream against the latched keystream and emits a byte-wide ciphertext stream.
- Both the plaintext and ciphertext sides use valid/ready handshakes, with a single registered output stage.

Parameters:
- NUMS_OF_BYTES, 4: keystream bytes per generator block. Must match the core's parameter. Minimum value is 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ks_start  out  1  one-cycle pulse requesting a new keystream block from the core.
- ks_done  in  1  core completion flag; level-type, may remain high after completion.
- ks_data  in  NUMS_OF_BYTES*8  keystream block from the core; byte k = ks_data[k*8 +: 8].
- pt_valid  in  1  plaintext byte valid.
- pt_data  in  8  plaintext byte.
- pt_last  in  1  marks the final byte of a message.
- pt_ready  out  1  plaintext byte accepted when pt_valid && pt_ready.
- ct_valid  out  1  ciphertext byte valid.
- ct_data  out  8  ciphertext byte.
- ct_last  out  1  last byte of the message.
- ct_ready  in  1  downstream accepts when ct_valid && ct_ready.
- busy  out  1  high in any state other than IDLE.
- blk_cnt  out  16  keystream blocks consumed in the current message.

Behaviour:
- Reset values: ks_start=0, pt_ready=0, ct_valid=0, ct_data=0, ct_last=0, busy=0, blk_cnt=0. Internally, state=IDLE, byte index=0, keystream buffer=0, ks_done_q=0.
- ks_done is registered into ks_done_q every cycle. A "done edge" is ks_done && !ks_done_q.
- A done edge is honoured only in WAIT_KS. In any other state it is ignored, which also discards a stale high level left over from an earlier block.
- IDLE:
  - pt_ready=0.
  - When pt_valid=1, go to REQ and clear blk_cnt.
- REQ:
  - Drive ks_start=1 for exactly this one cycle, then go to WAIT_KS.
- WAIT_KS:
  - ks_start=0 and pt_ready=0.
  - On a done edge, capture ks_data into the buffer, set byte index=0, increment blk_cnt, and go to STREAM. Total latency from REQ to STREAM is core latency + 2 cycles.
  - No timeout; the block waits indefinitely.
- STREAM:
  - pt_ready = !ct_valid || ct_ready (combinational).
  - On acceptance, register the outputs: ct_data <= pt_data ^ buf[idx*8 +: 8], ct_last <= pt_last, ct_valid <= 1.
  - Plaintext-to-ciphertext latency is 1 cycle.
  - Then:
    - if pt_last=1: go to DRAIN; unused keystream bytes are discarded.
    - else if idx == NUMS_OF_BYTES-1: go to REQ (byte index wraps to 0 on capture).
    - else idx++.
- DRAIN:
  - pt_ready=0.
  - When ct_valid && ct_ready, go to IDLE.
  - Each message starts from a freshly requested block.
- Output register:
  - ct_valid clears on a handshake unless a new byte is loaded in the same cycle. A simultaneous accept and load keeps ct_valid=1 with the new data.
  - While ct_valid=1 && ct_ready=0, ct_data and ct_last are held stable.
- In REQ and WAIT_KS, a pending ct byte still drains normally.
- Reset asserted mid-operation clears all state immediately:
  - any in-flight ct byte is lost;
  - blk_cnt returns to 0;
  - no ks_start is issued until a new pt_valid arrives after rst_n deasserts.
- blk_cnt wraps at 16 bits.

Test Plan:
- N=4, single block: core returns ks_data=32'h44332211. Plaintext 00,FF,A5,5A with last on the 4th byte and ct_ready=1 -> ct 11,DD,96,1E; ct_last set on the 4th byte only; one ks_start pulse; blk_cnt=1; IDLE afterwards.
- Multi-block: 6-byte message with all-00 plaintext; core returns 32'h44332211 then 32'h88776655 -> ct 11,22,33,44,55,66; exactly two ks_start pulses; bytes 77,88 discarded; blk_cnt=2.
- Backpressure: hold ct_ready=0 for 5 cycles after the first byte -> pt_ready=0 and ct_data=11 stable throughout; no byte lost or duplicated after release.
- Stale done: ks_done held high from the previous block when REQ fires -> no capture until ks_done falls and rises again; capture then uses the new ks_data.
- Short message: pt_last on byte 2 of a block -> DRAIN then IDLE; the next message issues a new ks_start and the first ct byte uses byte 0 of the new block.
- Reset mid-STREAM: assert rst_n=0 after byte 2 -> ct_valid=0, busy=0, blk_cnt=0 immediately; after release with pt_valid=1, ks_start is pulsed again.
